wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; AW = clog2(NREGS).
REQ-003 SHALL have parameter NWB, default 2, meaning writeback channels.
REQ-004 SHALL have parameter NRP, default 2, meaning read ports.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port stall  in  1  combined pipeline stall; freezes all state updates.
REQ-008 SHALL have port wb_valid  in  NWB  per-channel write request.
REQ-009 SHALL have port wb_rd  in  NWB*AW  per-channel destination index.
REQ-010 SHALL have port wb_sel_mem  in  NWB  per-channel select: 1 = memory data, 0 = ALU result.
REQ-011 SHALL have port wb_mem_data  in  NWB*XLEN  per-channel load data.
REQ-012 SHALL have port wb_alu_data  in  NWB*XLEN  per-channel ALU result.
REQ-013 SHALL have port iss_valid  in  1  issue marks destination pending.
REQ-014 SHALL have port iss_rd  in  AW  issued destination index.
REQ-015 SHALL have port rd_addr  in  NRP*AW  read addresses.
REQ-016 SHALL have port rd_data  out  NRP*XLEN  read data, combinational.
REQ-017 SHALL have port rd_busy  out  NRP  read register has an outstanding writer.
REQ-018 SHALL have port busy_vec  out  NREGS  scoreboard state.

Function
REQ-019 Channel i write data SHALL be wb_sel_mem[i] ? wb_mem_data[i] : wb_alu_data[i], full XLEN, no extension.
REQ-020 Channel i SHALL commit on the rising edge when wb_valid[i]=1, stall=0, wb_rd[i]!=0.
REQ-021 Register 0 SHALL read as 0 always; writes and issues to index 0 SHALL be ignored.
REQ-022 Two channels targeting the same index in one cycle: highest-numbered channel SHALL win.
REQ-023 Indices >= NREGS (non-power-of-two NREGS) SHALL be ignored on write and read as 0.
REQ-024 Read port j SHALL bypass: if a committing channel (REQ-020) targets rd_addr[j], rd_data[j] SHALL equal that channel's write data (REQ-022 priority); else array contents.
REQ-025 Write latency: visible via bypass same cycle, via array from next cycle.
REQ-026 Scoreboard: iss_valid=1, stall=0, iss_rd!=0 SHALL set busy bit iss_rd next edge.
REQ-027 A commit (REQ-020) SHALL clear busy bit wb_rd[i] next edge.
REQ-028 Set and clear of the same bit in one cycle: set SHALL win (newer producer pending).
REQ-029 rd_busy[j] SHALL be busy bit of rd_addr[j] AND NOT cleared by a commit this cycle; 0 for index 0.
REQ-030 stall=1 SHALL hold registers and scoreboard unchanged; bypass SHALL be suppressed.
REQ-031 Commit to a non-busy register SHALL still write; busy bit stays 0.

Reset
REQ-032 reset=1 SHALL asynchronously clear all registers and all busy bits to 0.
REQ-033 During reset rd_data SHALL read 0, rd_busy and busy_vec SHALL be 0; writes and issues ignored.
REQ-034 Reset deassertion mid-operation SHALL need no flush; first edge after deassert accepts writes.

Structure
REQ-035 Package wb_pkg SHALL hold XLEN/NREGS defaults, AW derivation, and writeback-channel struct typedef (valid, rd, sel_mem, mem_data, alu_data).
REQ-036 Scoreboard SHALL be sub-module wb_scoreboard (set/clear/priority, busy_vec); array, mux, bypass stay in wb_regfile.

Verification
REQ-037 Reset, ch0 write rd=5 alu=0x1234 -> rd_data(5)=0x1234 same cycle (bypass), still 0x1234 next cycle.
REQ-038 ch0 rd=7 alu=0xAAAA, ch1 rd=7 mem=0x5555 sel_mem=1, same cycle -> reg7=0x5555.
REQ-039 Write rd=0 data=0xFFFFFFFF -> rd_data(0)=0; issue rd=0 -> busy_vec[0]=0.
REQ-040 stall=1 with write rd=3 0xBEEF -> reg3 unchanged, no bypass; stall=0 next -> reg3=0xBEEF.
REQ-041 Issue rd=9; later commit rd=9 with issue rd=9 same cycle -> busy_vec[9]=1; lone commit -> 0; rd_busy(9)=0 in commit cycle.
REQ-042 Assert reset mid-write of rd=4 0x77 -> reg4=0, busy_vec=0 immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared defaults and types for the writeback register file and its scoreboard.
package wb_pkg;

    localparam int WB_XLEN  = 32;
    localparam int WB_NREGS = 32;

    // Index width for a given register count; never narrower than one bit.
    function automatic int wb_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int WB_AW = wb_aw(WB_NREGS);

    typedef struct packed {
        logic               valid;
        logic [WB_AW-1:0]   rd;
        logic               sel_mem;
        logic [WB_XLEN-1:0] mem_data;
        logic [WB_XLEN-1:0] alu_data;
    } wb_chan_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard: issue sets a destination pending, commit clears it.
module wb_scoreboard import wb_pkg::*; #(
    parameter int NREGS = WB_NREGS,
    parameter int NWB   = 2,
    parameter int NRP   = 2,
    parameter int AW    = wb_aw(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWB-1:0]    commit,
    input  logic [NWB*AW-1:0] wb_rd,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP-1:0]    rd_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             set_en;
    logic [AW-1:0]    raddr;

    // Clears are applied first so a same-cycle issue to the same index wins.
    always_comb begin
        set_en = iss_valid && !stall && (iss_rd != '0) && (32'(iss_rd) < NREGS);
        busy_d = busy_q;
        for (int unsigned i = 0; i < NWB; i++) begin
            if (commit[i]) begin
                busy_d[wb_rd[i*AW +: AW]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_comb begin
        rd_busy = '0;
        raddr   = '0;
        for (int unsigned j = 0; j < NRP; j++) begin
            raddr      = rd_addr[j*AW +: AW];
            rd_busy[j] = (raddr != '0) && (32'(raddr) < NREGS) && busy_q[raddr];
            for (int unsigned i = 0; i < NWB; i++) begin
                if (commit[i] && (wb_rd[i*AW +: AW] == raddr)) begin
                    rd_busy[j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/wb_regfile.sv
// Multi-channel writeback register file with same-cycle bypass and busy scoreboard.
module wb_regfile import wb_pkg::*; #(
    parameter int XLEN  = WB_XLEN,
    parameter int NREGS = WB_NREGS,
    parameter int NWB   = 2,
    parameter int NRP   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [NWB-1:0]                 wb_valid,
    input  logic [NWB*wb_aw(NREGS)-1:0]    wb_rd,
    input  logic [NWB-1:0]                 wb_sel_mem,
    input  logic [NWB*XLEN-1:0]            wb_mem_data,
    input  logic [NWB*XLEN-1:0]            wb_alu_data,
    input  logic                           iss_valid,
    input  logic [wb_aw(NREGS)-1:0]        iss_rd,
    input  logic [NRP*wb_aw(NREGS)-1:0]    rd_addr,
    output logic [NRP*XLEN-1:0]            rd_data,
    output logic [NRP-1:0]                 rd_busy,
    output logic [NREGS-1:0]               busy_vec
);

    localparam int AW = wb_aw(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] wdata  [NWB];
    logic [AW-1:0]   wrd    [NWB];
    logic [NWB-1:0]  commit;
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rval;

    // Index 0 and out-of-range indices never commit, so they stay zero.
    always_comb begin
        for (int unsigned i = 0; i < NWB; i++) begin
            wrd[i]    = wb_rd[i*AW +: AW];
            wdata[i]  = wb_sel_mem[i] ? wb_mem_data[i*XLEN +: XLEN]
                                      : wb_alu_data[i*XLEN +: XLEN];
            commit[i] = wb_valid[i] && !stall && !reset &&
                        (wrd[i] != '0) && (32'(wrd[i]) < NREGS);
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NWB; i++) begin
            if (commit[i]) begin
                regs_d[wrd[i]] = wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Ascending channel scan lets the highest-numbered committing channel win the bypass.
    always_comb begin
        rd_data = '0;
        raddr   = '0;
        rval    = '0;
        for (int unsigned j = 0; j < NRP; j++) begin
            raddr = rd_addr[j*AW +: AW];
            rval  = '0;
            if (32'(raddr) < NREGS) begin
                rval = regs_q[raddr];
            end
            for (int unsigned i = 0; i < NWB; i++) begin
                if (commit[i] && (wrd[i] == raddr)) begin
                    rval = wdata[i];
                end
            end
            if (reset) begin
                rval = '0;
            end
            rd_data[j*XLEN +: XLEN] = rval;
        end
    end

    wb_scoreboard #(
        .NREGS (NREGS),
        .NWB   (NWB),
        .NRP   (NRP),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .commit    (commit),
        .wb_rd     (wb_rd),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile using a non-power-of-two register count.
module tb_wb_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int NWB   = 2;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  reset;
    logic                  stall;
    logic [NWB-1:0]        wb_valid;
    logic [NWB*AW-1:0]     wb_rd;
    logic [NWB-1:0]        wb_sel_mem;
    logic [NWB*XLEN-1:0]   wb_mem_data;
    logic [NWB*XLEN-1:0]   wb_alu_data;
    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic [NRP*AW-1:0]     rd_addr;
    logic [NRP*XLEN-1:0]   rd_data;
    logic [NRP-1:0]        rd_busy;
    logic [NREGS-1:0]      busy_vec;

    int checks;
    int errors;

    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];

    wb_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NWB   (NWB),
        .NRP   (NRP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_sel_mem  (wb_sel_mem),
        .wb_mem_data (wb_mem_data),
        .wb_alu_data (wb_alu_data),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int ch_rd(input int i);
        return int'(wb_rd[i*AW +: AW]);
    endfunction

    function automatic logic [XLEN-1:0] ch_data(input int i);
        return wb_sel_mem[i] ? wb_mem_data[i*XLEN +: XLEN] : wb_alu_data[i*XLEN +: XLEN];
    endfunction

    function automatic bit ch_commit(input int i);
        return (wb_valid[i] === 1'b1) && (stall === 1'b0) && (reset === 1'b0) &&
               (ch_rd(i) != 0) && (ch_rd(i) < NREGS);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int a);
        logic [XLEN-1:0] r;
        r = '0;
        if (reset) return '0;
        if (a > 0 && a < NREGS) r = m_reg[a];
        for (int i = 0; i < NWB; i++)
            if (ch_commit(i) && ch_rd(i) == a) r = ch_data(i);
        return r;
    endfunction

    function automatic bit exp_rbusy(input int a);
        bit b;
        if (reset || a == 0 || a >= NREGS) return 1'b0;
        b = m_busy[a];
        for (int i = 0; i < NWB; i++)
            if (ch_commit(i) && ch_rd(i) == a) b = 1'b0;
        return b;
    endfunction

    function automatic logic [NREGS-1:0] exp_busy_vec();
        logic [NREGS-1:0] v;
        for (int k = 0; k < NREGS; k++) v[k] = m_busy[k];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NREGS; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Advance one clock; the model updates from the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < NWB; i++) begin
                if (ch_commit(i)) begin
                    m_reg[ch_rd(i)]  = ch_data(i);
                    m_busy[ch_rd(i)] = 1'b0;
                end
            end
            if (iss_valid && !stall && iss_rd != '0 && int'(iss_rd) < NREGS)
                m_busy[int'(iss_rd)] = 1'b1;
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        stall       = 1'b0;
        wb_valid    = '0;
        wb_rd       = '0;
        wb_sel_mem  = '0;
        wb_mem_data = '0;
        wb_alu_data = '0;
        iss_valid   = 1'b0;
        iss_rd      = '0;
        rd_addr     = '0;
    endtask

    task automatic set_ch(input int i, input bit v, input int rd, input bit sel,
                          input logic [XLEN-1:0] mem, input logic [XLEN-1:0] alu);
        wb_valid[i]              = v;
        wb_rd[i*AW +: AW]        = rd[AW-1:0];
        wb_sel_mem[i]            = sel;
        wb_mem_data[i*XLEN +: XLEN] = mem;
        wb_alu_data[i*XLEN +: XLEN] = alu;
    endtask

    task automatic set_port(input int j, input int a);
        rd_addr[j*AW +: AW] = a[AW-1:0];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        clear_inputs();
        set_ch(0, 1, 5, 0, '0, 32'hDEAD_0005);
        set_port(0, 5);
        iss_valid = 1'b1;
        iss_rd    = 5'd6;
        #1;
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++;
        if (rd_busy !== '0) begin errors++; $display("FAIL reset_rd_busy got=%b exp=0", rd_busy); end
        checks++;
        if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
        tick();
        checks++;
        if (busy_vec !== '0) begin errors++; $display("FAIL reset_issue_ignored got=%h exp=0", busy_vec); end
        reset = 1'b0;
        clear_inputs();
        set_port(0, 5);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL reset_write_ignored got=%h exp=0", rd_data[0 +: XLEN]);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        set_ch(0, 1, 5, 0, 32'h0, 32'h1234);
        set_port(0, 5);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h1234) begin
            errors++; $display("FAIL bypass_same_cycle got=%h exp=00001234", rd_data[0 +: XLEN]);
        end
        tick();
        clear_inputs();
        set_port(0, 5);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h1234) begin
            errors++; $display("FAIL array_next_cycle got=%h exp=00001234", rd_data[0 +: XLEN]);
        end
    endtask

    task automatic test_same_index();
        clear_inputs();
        set_ch(0, 1, 7, 0, 32'h0, 32'hAAAA);
        set_ch(1, 1, 7, 1, 32'h5555, 32'h0);
        set_port(1, 7);
        #1;
        checks++;
        if (rd_data[XLEN +: XLEN] !== 32'h5555) begin
            errors++; $display("FAIL priority_bypass got=%h exp=00005555", rd_data[XLEN +: XLEN]);
        end
        tick();
        clear_inputs();
        set_port(1, 7);
        #1;
        checks++;
        if (rd_data[XLEN +: XLEN] !== 32'h5555) begin
            errors++; $display("FAIL priority_array got=%h exp=00005555", rd_data[XLEN +: XLEN]);
        end
    endtask

    task automatic test_reg0();
        clear_inputs();
        set_ch(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFF);
        iss_valid = 1'b1;
        iss_rd    = '0;
        set_port(0, 0);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL reg0_bypass got=%h exp=0", rd_data[0 +: XLEN]);
        end
        tick();
        clear_inputs();
        set_port(0, 0);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL reg0_array got=%h exp=0", rd_data[0 +: XLEN]);
        end
        checks++;
        if (busy_vec[0] !== 1'b0) begin
            errors++; $display("FAIL reg0_busy got=%b exp=0", busy_vec[0]);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        stall = 1'b1;
        set_ch(0, 1, 3, 0, 32'h0, 32'hBEEF);
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        set_port(0, 3);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL stall_no_bypass got=%h exp=0", rd_data[0 +: XLEN]);
        end
        tick();
        clear_inputs();
        set_port(0, 3);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL stall_hold_reg got=%h exp=0", rd_data[0 +: XLEN]);
        end
        checks++;
        if (busy_vec[3] !== 1'b0) begin
            errors++; $display("FAIL stall_hold_busy got=%b exp=0", busy_vec[3]);
        end
        set_ch(0, 1, 3, 0, 32'h0, 32'hBEEF);
        tick();
        clear_inputs();
        set_port(0, 3);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'hBEEF) begin
            errors++; $display("FAIL unstall_write got=%h exp=0000beef", rd_data[0 +: XLEN]);
        end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        tick();
        clear_inputs();
        set_port(0, 9);
        #1;
        checks++;
        if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL issue_sets_busy got=%b exp=1", busy_vec[9]); end
        checks++;
        if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rd_busy_pending got=%b exp=1", rd_busy[0]); end
        set_ch(0, 1, 9, 0, 32'h0, 32'h99);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL rd_busy_commit_cycle got=%b exp=0", rd_busy[0]); end
        tick();
        clear_inputs();
        set_port(0, 9);
        #1;
        checks++;
        if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b exp=1", busy_vec[9]); end
        set_ch(0, 1, 9, 0, 32'h0, 32'h999);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL rd_busy_lone_commit got=%b exp=0", rd_busy[0]); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL commit_clears_busy got=%b exp=0", busy_vec[9]); end
        set_ch(1, 1, 10, 1, 32'hCAFE, 32'h0);
        tick();
        clear_inputs();
        set_port(1, 10);
        #1;
        checks++;
        if (rd_data[XLEN +: XLEN] !== 32'hCAFE) begin
            errors++; $display("FAIL nonbusy_write got=%h exp=0000cafe", rd_data[XLEN +: XLEN]);
        end
        checks++;
        if (busy_vec[10] !== 1'b0) begin errors++; $display("FAIL nonbusy_stays_clear got=%b exp=0", busy_vec[10]); end
    endtask

    task automatic test_out_of_range();
        clear_inputs();
        set_ch(0, 1, 25, 0, 32'h0, 32'h5A5A);
        set_ch(1, 1, 23, 0, 32'h0, 32'h2323);
        iss_valid = 1'b1;
        iss_rd    = 5'd30;
        set_port(0, 25);
        set_port(1, 23);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL oor_bypass got=%h exp=0", rd_data[0 +: XLEN]);
        end
        tick();
        clear_inputs();
        set_port(0, 25);
        set_port(1, 23);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL oor_array got=%h exp=0", rd_data[0 +: XLEN]);
        end
        checks++;
        if (rd_data[XLEN +: XLEN] !== 32'h2323) begin
            errors++; $display("FAIL top_index_write got=%h exp=00002323", rd_data[XLEN +: XLEN]);
        end
        checks++;
        if (busy_vec !== exp_busy_vec()) begin
            errors++; $display("FAIL oor_issue got=%h exp=%h", busy_vec, exp_busy_vec());
        end
    endtask

    task automatic test_random();
        int a;
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            stall = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NWB; i++)
                set_ch(i, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31)),
                       $urandom_range(0, 1) == 1, $urandom, $urandom);
            iss_valid = $urandom_range(0, 1) == 1;
            a = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            iss_rd = a[AW-1:0];
            for (int j = 0; j < NRP; j++)
                set_port(j, $urandom_range(0, 1) ? ch_rd(j % NWB) : int'($urandom_range(0, 31)));
            #1;
            for (int j = 0; j < NRP; j++) begin
                a = int'(rd_addr[j*AW +: AW]);
                checks++;
                if (rd_data[j*XLEN +: XLEN] !== exp_rd(a)) begin
                    errors++;
                    $display("FAIL rand_rd_data c=%0d port=%0d addr=%0d got=%h exp=%h",
                             c, j, a, rd_data[j*XLEN +: XLEN], exp_rd(a));
                end
                checks++;
                if (rd_busy[j] !== exp_rbusy(a)) begin
                    errors++;
                    $display("FAIL rand_rd_busy c=%0d port=%0d addr=%0d got=%b exp=%b",
                             c, j, a, rd_busy[j], exp_rbusy(a));
                end
            end
            checks++;
            if (busy_vec !== exp_busy_vec()) begin
                errors++; $display("FAIL rand_busy_vec c=%0d got=%h exp=%h", c, busy_vec, exp_busy_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        iss_valid = 1'b1;
        iss_rd    = 5'd12;
        set_ch(0, 1, 4, 0, 32'h0, 32'h77);
        set_port(0, 4);
        tick();
        iss_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            errors++; $display("FAIL mid_reset_reg4 got=%h exp=0", rd_data[0 +: XLEN]);
        end
        checks++;
        if (busy_vec !== '0) begin errors++; $display("FAIL mid_reset_busy got=%h exp=0", busy_vec); end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h77) begin
            errors++; $display("FAIL post_reset_bypass got=%h exp=00000077", rd_data[0 +: XLEN]);
        end
        tick();
        clear_inputs();
        set_port(0, 4);
        #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h77) begin
            errors++; $display("FAIL post_reset_write got=%h exp=00000077", rd_data[0 +: XLEN]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_bypass();
        test_same_index();
        test_reg0();
        test_stall();
        test_scoreboard();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
